wb_mem_slave: RTL and testbench

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

---
 rtl/wb_mem_slave.sv | 141 ++++++++++++++
 tb/tb_wb_mem_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_slave.sv
`default_nettype none
// =====================================================================
// Module   : wb_mem_slave
// Brief    : Pipelined Wishbone memory slave, fixed-latency in-order
//            responses, byte-lane writes and optional stall injection.
// Revision : 1.0
// =====================================================================
module wb_mem_slave #(
    parameter int ADR_WIDTH   = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 1,
    parameter int MAX_OUT     = 4,
    parameter int STALL_EVERY = 0,
    parameter int STALL_LEN   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic                   we,
    input  logic [ADR_WIDTH-1:0]   adr,
    input  logic [DAT_WIDTH/8-1:0] sel,
    input  logic [DAT_WIDTH-1:0]   dat_m,
    output logic                   stall,
    output logic                   ack,
    output logic                   err,
    output logic [DAT_WIDTH-1:0]   dat_s
);
    localparam int c_lanes = DAT_WIDTH / 8;
    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(MAX_OUT + 1);
    localparam int c_acc_w = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

    logic [DAT_WIDTH-1:0] mem [DEPTH];

    logic [c_idx_w-1:0]   w_idx;
    logic                 w_oor;
    logic                 w_accept;
    logic                 w_rsp;
    logic [DAT_WIDTH-1:0] w_rdata;

    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [LATENCY-1:0]   err_q, err_d;
    logic [DAT_WIDTH-1:0] dat_q [LATENCY];
    logic [DAT_WIDTH-1:0] dat_d [LATENCY];
    logic [c_cnt_w-1:0]   out_cnt_q, out_cnt_d;
    logic [c_acc_w-1:0]   acc_cnt_q, acc_cnt_d;
    logic [3:0]           stall_cnt_q, stall_cnt_d;

    assign w_idx    = adr[c_idx_w+1:2];
    assign w_oor    = |(adr >> (c_idx_w + 2));
    assign w_accept = cyc & stb & ~stall;
    assign w_rdata  = mem[w_idx];

    // Stall is a pure function of registered state, never of this cycle's inputs.
    assign stall = (out_cnt_q == c_cnt_w'(MAX_OUT)) || (stall_cnt_q != 4'd0);

    // Dropping cyc suppresses a response already sitting at the pipe output.
    assign w_rsp = vld_q[LATENCY-1] & cyc;
    assign ack   = w_rsp & ~err_q[LATENCY-1];
    assign err   = w_rsp & err_q[LATENCY-1];
    assign dat_s = w_rsp ? dat_q[LATENCY-1] : '0;

    always_ff @(posedge clk) begin
        if (w_accept && we && !w_oor) begin
            for (int b = 0; b < c_lanes; b++) begin
                if (sel[b]) begin
                    mem[w_idx][8*b +: 8] <= dat_m[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        vld_d = '0;
        err_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            dat_d[i] = '0;
        end
        vld_d[0] = w_accept;
        err_d[0] = w_accept & w_oor;
        dat_d[0] = (w_accept && !we && !w_oor) ? w_rdata : '0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        if (!cyc) begin
            vld_d = '0;
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (!cyc) begin
            out_cnt_d = '0;
        end else if (w_accept && !w_rsp) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!w_accept && w_rsp) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = (stall_cnt_q != 4'd0) ? stall_cnt_q - 4'd1 : 4'd0;
        acc_cnt_d   = acc_cnt_q;
        if (STALL_EVERY != 0 && w_accept) begin
            if (acc_cnt_q == c_acc_w'(STALL_EVERY - 1)) begin
                acc_cnt_d   = '0;
                stall_cnt_d = 4'(STALL_LEN);
            end else begin
                acc_cnt_d = acc_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            err_q       <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
            out_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            err_q       <= err_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
            out_cnt_q   <= out_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_slave.sv
`default_nettype none
// =====================================================================
// Module   : tb_wb_mem_slave
// Brief    : Scoreboard bench for wb_mem_slave with a reference memory.
// Revision : 1.0
// =====================================================================
module tb_wb_mem_slave;
    localparam int DEPTH       = 1024;
    localparam int LATENCY     = 3;
    localparam int MAX_OUT     = 2;
    localparam int STALL_EVERY = 5;
    localparam int STALL_LEN   = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] adr   = '0;
    logic [3:0]  sel   = '0;
    logic [31:0] dat_m = '0;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] dat_s;

    wb_mem_slave #(
        .ADR_WIDTH  (32),
        .DAT_WIDTH  (32),
        .DEPTH      (DEPTH),
        .LATENCY    (LATENCY),
        .MAX_OUT    (MAX_OUT),
        .STALL_EVERY(STALL_EVERY),
        .STALL_LEN  (STALL_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cyc  (cyc),
        .stb  (stb),
        .we   (we),
        .adr  (adr),
        .sel  (sel),
        .dat_m(dat_m),
        .stall(stall),
        .ack  (ack),
        .err  (err),
        .dat_s(dat_s)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [DEPTH];
    int          n_acc       = 0;
    int          stall_until = 0;
    bit          done        = 1'b0;
    int          checks      = 0;
    int          errors      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc_n, act, expv);
        end
    endtask

    // Monitor: every cycle compare outputs with the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_stall", 32'(stall), 32'd0);
            chk("reset_ack",   32'(ack),   32'd0);
            chk("reset_err",   32'(err),   32'd0);
            chk("reset_dat_s", dat_s,      32'd0);
            exp_q.delete();
        end else begin
            chk("stall", 32'(stall),
                32'((exp_q.size() >= MAX_OUT) || (cyc_n < stall_until)));
            if (cyc && exp_q.size() != 0 && exp_q[0].due == cyc_n) begin
                mon_e = exp_q.pop_front();
                chk("ack",   32'(ack), 32'(!mon_e.is_err));
                chk("err",   32'(err), 32'(mon_e.is_err));
                chk("dat_s", dat_s,    mon_e.data);
            end else begin
                chk("idle_ack",   32'(ack), 32'd0);
                chk("idle_err",   32'(err), 32'd0);
                chk("idle_dat_s", dat_s,    32'd0);
            end
            if (!cyc) begin
                exp_q.delete();
            end
        end
        if (done) begin
            chk("drained", 32'(exp_q.size()), 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Hold the request until the slave takes it, then record the expected response.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        int   k;
        int   wait_n;
        exp_t e;
        wait_n = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_m = d;
        @(negedge clk);
        while (stall) begin
            wait_n++;
            if (wait_n > 20) begin
                $display("FAIL accept_timeout: cycle %0d got stall=1 expected accept", cyc_n);
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
        end
        k = cyc_n;
        @(posedge clk);
        #1;
        stb      = 1'b0;
        e.due    = k + LATENCY;
        e.is_err = |a[31:12];
        e.data   = '0;
        if (!e.is_err) begin
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                e.data = ref_mem[a[11:2]];
            end
        end
        exp_q.push_back(e);
        n_acc++;
        if (n_acc % STALL_EVERY == 0) begin
            stall_until = k + 1 + STALL_LEN;
        end
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drop_cyc();
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        #1;
        cyc = 1'b1;
    endtask

    task automatic do_reset();
        stb         = 1'b0;
        rst_n       = 1'b0;
        n_acc       = 0;
        stall_until = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 32'(i * 4), 4'hF, $urandom);
        end
        issue(1'b1, 32'h0000_0FFC, 4'hF, 32'hA5A5_5A5A);
        issue(1'b0, 32'h0000_0FFC, 4'hF, 32'h0);

        issue(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);

        issue(1'b1, 32'h0000_0020, 4'hF, 32'hFFFF_FFFF);
        issue(1'b1, 32'h0000_0020, 4'h5, 32'h1122_3344);
        issue(1'b0, 32'h0000_0020, 4'hF, 32'h0);

        issue(1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678);
        issue(1'b0, 32'h0000_1000, 4'hF, 32'h0);
        issue(1'b0, 32'h0000_0000, 4'hF, 32'h0);
        idle(6);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5) drop_cyc();
            else if (r < 20) idle($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) a = 32'h0000_1000 | $urandom;
            else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end
        idle(6);

        issue(1'b0, 32'h0000_0004, 4'hF, 32'h0);
        issue(1'b0, 32'h0000_0008, 4'hF, 32'h0);
        drop_cyc();
        idle(6);
        issue(1'b0, 32'h0000_0004, 4'hF, 32'h0);
        idle(6);

        issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        issue(1'b0, 32'h0000_0020, 4'hF, 32'h0);
        do_reset();
        issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        issue(1'b0, 32'h0000_0FFC, 4'hF, 32'h0);
        idle(LATENCY + 4);
        done = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: cycle %0d got no finish expected finish", cyc_n);
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
